// File: rtl/data_ram.sv
// rtl/data_ram.sv - single-port word RAM with valid/ready request and registered response.
// Optional post-reset fill sweep is compiled in with DATA_RAM_INIT_EN.
module data_ram #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 16,
    parameter int                DEPTH      = 65536,
    parameter logic [DATA_W-1:0] INIT_VALUE = DATA_W'(32'h0000_0005)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                init_busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              sweep_we;
    logic [IDX_W-1:0]  sweep_idx;
    logic              busy;
    logic              in_range;
    logic              accept;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_word;

    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;

`ifdef DATA_RAM_INIT_EN
    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + IDX_W'(1);
            if (cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end
    end

    always_comb begin
        busy      = (state_q == ST_INIT);
        sweep_we  = busy && reset;
        sweep_idx = cnt_q;
    end
`else
    assign busy      = 1'b0;
    assign sweep_we  = 1'b0;
    assign sweep_idx = '0;
`endif

    assign init_busy = busy;
    assign in_range  = ({1'b0, req_addr} < (ADDR_W + 1)'(DEPTH));
    // Ready is held low while reset is asserted even when no sweep exists.
    assign req_ready = reset && !busy && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && req_ready;

    always_comb begin
        mem_we    = sweep_we || (accept && req_we && in_range);
        mem_idx   = sweep_we ? sweep_idx : req_addr[IDX_W-1:0];
        mem_be    = sweep_we ? {BE_W{1'b1}} : req_be;
        mem_wdata = sweep_we ? INIT_VALUE : req_wdata;
        rd_word   = mem[req_addr[IDX_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (mem_be[i]) begin
                    mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = !in_range;
            rsp_rdata_d = (!req_we && in_range) ? rd_word : '0;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
